sha_msg_loader: RTL and testbench
=================================

Name: sha_msg_loader

Overview:
Upstream feeder for sha_core. Collects one 512-bit message block from a narrow write port, 128-bit words by default, and presents it on sha_core's message input. Pulses sha_core's start input, waits for its valid, then captures and holds the 256-bit hash for the bus side. Each block is hashed independently; there is no multi-block chaining.

Parameters:
WORD_W, 128, write word width; legal values 32, 64, 128; NUM_WORDS = 512/WORD_W is a derived localparam.
TIMEOUT_CYC, 1023, maximum WAIT cycles before abort; used only with SHA_LOADER_TIMEOUT_EN.

Ports:
clk  input  1  clock, rising edge.
clr  input  1  synchronous active-low reset.
wr_en  input  1  write strobe, upstream side.
wr_data  input  WORD_W  write word; first word is the MSBs of the block.
wr_ready  output  1  loader accepts a word this cycle.
message  output  512  block to sha_core.message.
start  output  1  one-cycle start pulse to sha_core.start.
core_valid  input  1  sha_core.valid.
core_hash  input  256  sha_core.hashvalue.
hash_out  output  256  captured digest.
hash_valid  output  1  hash_out holds a fresh digest.
busy  output  1  block loaded and a hash is in flight.
timeout_err  output  1  sticky abort flag; tied 0 without the macro.

Behaviour:
- Clock is clk. Reset is clr: synchronous, active-low. All state is updated on the rising edge of clk.
- Reset (clr==0 at an edge):
  - state=LOAD, cnt=0.
  - message=0, hash_out=0.
  - start=0, hash_valid=0, timeout_err=0.
  - wr_ready is gated to 0 while clr==0.
- States: LOAD -> START -> WAIT -> LOAD.
- LOAD:
  - wr_ready=1, busy=0.
  - Accept on wr_en&&wr_ready: word cnt goes to message[511-cnt*WORD_W -: WORD_W]; cnt increments.
  - Accepting word cnt==NUM_WORDS-1 moves to START and clears cnt.
  - wr_en gaps are allowed; cnt holds.
  - The first accepted word of a block clears hash_valid and timeout_err.
- START:
  - Exactly one cycle with start=1, wr_ready=0, busy=1.
  - Always goes to WAIT.
  - core_valid is ignored here.
- WAIT:
  - start=0, wr_ready=0, busy=1.
  - On core_valid==1: hash_out<=core_hash, hash_valid<=1, go to LOAD.
  - hash_valid stays set until the next block's first accepted word or reset.
- message is registered and stable from the last accepted word through the end of WAIT.
  - It is not cleared between blocks; it is overwritten slice by slice.
- wr_en while wr_ready==0 is dropped silently: no count change, no data change.
- core_valid in LOAD is ignored, so a stale core output is never captured.
- Latency:
  - Last word accepted at edge k: start is high in cycle k..k+1.
  - core_valid sampled at edge m: hash_valid and hash_out update at edge m; visible in the cycle after edge m.
  - Earliest next word is accepted at edge m+1.
- Reset mid-operation (any state): discard the partial block or in-flight hash; return to LOAD with cnt=0.
  - The sha_core shares clr, so it resets too.
- cnt width is clog2(NUM_WORDS), minimum 1 bit. cnt never exceeds NUM_WORDS-1 because it wraps to 0 on entering START.

Optional Feature:
SHA_LOADER_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter clears on entering WAIT.
  - If it reaches TIMEOUT_CYC without core_valid, go to LOAD and set timeout_err=1 (sticky).
  - hash_valid stays 0 and hash_out is unchanged.
  - core_valid arriving in the same cycle as the timeout wins: normal capture, no error.
- Undefined: no counter is built; timeout_err is tied 0; WAIT lasts until core_valid.

Test Plan:
1. clr=0 for 1 cycle, then 1. Write 4 words: 0x61626380_00000000_00000000_00000000, two all-zero words, then 0x00000000_00000000_00000000_00000018 -> one-cycle start; message equals the padded "abc" block; busy=1. The sha_core then reports valid -> hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, hash_valid=1, busy=0.
2. Words written with 3-cycle wr_en gaps -> same message and exactly one start pulse after the 4th word. No start appears after words 1-3.
3. wr_en=1 with 0xDEADBEEF… words throughout START/WAIT -> wr_ready=0; message unchanged; after the hash, cnt=0 and the next write lands in bits 511:384.
4. clr=0 after 2 of 4 words, then clr=1 -> wr_ready=1, cnt=0, hash_valid=0. 4 new words produce a fresh block with no stale slices from the first 2 words.
5. Back-to-back blocks: "abc" then empty-string block 0x80000000_…_00000000 -> hash_valid drops on the first word of block 2. Block 2 yields e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
6. With SHA_LOADER_TIMEOUT_EN, TIMEOUT_CYC=16, core_valid held 0 -> after 16 WAIT cycles state is LOAD, timeout_err=1, hash_valid=0. The next first-word write clears timeout_err.

Source files
------------

// File: rtl/sha_msg_loader.sv
// sha_msg_loader: upstream feeder for sha_core.
// Collects one 512-bit block from WORD_W-bit writes, MSB word first.
// Pulses start for one cycle, then waits for the core's valid.
// On valid it captures and holds the 256-bit digest.
// Each block is hashed on its own; there is no chaining between blocks.
//
// Handshake: a word transfers on a rising edge where wr_en && wr_ready.
// wr_ready is high only in LOAD and only while clr is high.
// A write offered while wr_ready is low is dropped without side effects.
// core_valid is acted on only in WAIT.
//
// Optional build macro SHA_LOADER_TIMEOUT_EN:
//   WAIT gives up after TIMEOUT_CYC cycles without core_valid.
//   The loader then returns to LOAD and sets the sticky flag timeout_err.
//   Without the macro, no counter is built and timeout_err is tied to 0.
module sha_msg_loader #(
    parameter int WORD_W      = 128,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [511:0]      message,
    output logic              start,
    input  logic              core_valid,
    input  logic [255:0]      core_hash,
    output logic [255:0]      hash_out,
    output logic              hash_valid,
    output logic              busy,
    output logic              timeout_err
);

    localparam int NUM_WORDS = 512 / WORD_W;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [511:0]     message_q;
    logic [255:0]     hash_out_q;
    logic             hash_valid_q;
    logic             start_q;
    logic             accept;
    logic [8:0]       slice_hi;

`ifdef SHA_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] wait_cnt_q;
    logic            timeout_err_q;
`endif

    // Word slot: word 0 fills bits 511 downward.
    assign slice_hi = 9'(511 - int'(cnt_q) * WORD_W);

    // Ready is held low during reset, so a write is never taken under clr=0.
    assign wr_ready = clr && (state_q == ST_LOAD);
    assign accept   = wr_en && wr_ready;
    assign busy     = (state_q != ST_LOAD);

    assign message    = message_q;
    assign hash_out   = hash_out_q;
    assign hash_valid = hash_valid_q;
    assign start      = start_q;

`ifdef SHA_LOADER_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYC;
`endif

    // Loader FSM: collect words, pulse start, wait for and capture the digest.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q      <= ST_LOAD;
            cnt_q        <= '0;
            message_q    <= '0;
            hash_out_q   <= '0;
            hash_valid_q <= 1'b0;
            start_q      <= 1'b0;
`ifdef SHA_LOADER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        message_q[slice_hi -: WORD_W] <= wr_data;
                        // A new block makes the previous result stale.
                        if (cnt_q == '0) begin
                            hash_valid_q <= 1'b0;
`ifdef SHA_LOADER_TIMEOUT_EN
                            timeout_err_q <= 1'b0;
`endif
                        end
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            state_q <= ST_START;
                            start_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
`ifdef SHA_LOADER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ST_WAIT: begin
                    // If core_valid and the timeout land in the same cycle,
                    // the digest is captured and no error is raised.
                    if (core_valid) begin
                        hash_out_q   <= core_hash;
                        hash_valid_q <= 1'b1;
                        state_q      <= ST_LOAD;
                    end
`ifdef SHA_LOADER_TIMEOUT_EN
                    else if (wait_cnt_q == TO_LAST) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_LOAD;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_msg_loader.sv
// Testbench for sha_msg_loader (128-bit words, 4 words per block).
// Block vectors are kept in a table.
// Hand-written sequences cover:
//   - core_valid arriving outside WAIT
//   - writes offered while busy
//   - reset in the middle of a block
//   - timeout, in builds that define SHA_LOADER_TIMEOUT_EN
module tb_sha_msg_loader;

  localparam int WORD_W = 128;
`ifdef SHA_LOADER_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1023;
`endif

  localparam logic [511:0] ABC_MSG = {
    32'h61626380, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000018};
  localparam logic [511:0] EMPTY_MSG = {
    32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
  localparam logic [511:0] PAT_MSG = {
    32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
    32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
    32'hffffffff, 32'h00000000, 32'hffffffff, 32'h00000000,
    32'h13579bdf, 32'h2468ace0, 32'h0f1e2d3c, 32'h4b5a6978};
  localparam logic [255:0] ABC_HASH =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_HASH =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] PAT_HASH =
    256'h0badc0de_11112222_33334444_55556666_77778888_9999aaaa_bbbbcccc_ddddeeee;
  localparam logic [255:0] JUNK_HASH = {8{32'hbadbadff}};

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              wr_en = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic [511:0]      message;
  logic              start;
  logic              core_valid = 1'b0;
  logic [255:0]      core_hash = '0;
  logic [255:0]      hash_out;
  logic              hash_valid;
  logic              busy;
  logic              timeout_err;

  always #5 clk = ~clk;

  sha_msg_loader #(.WORD_W(WORD_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .message(message), .start(start), .core_valid(core_valid), .core_hash(core_hash),
    .hash_out(hash_out), .hash_valid(hash_valid), .busy(busy), .timeout_err(timeout_err)
  );

  // Start pulses, sampled mid-cycle.
  int start_cnt = 0;
  always @(negedge clk) if (start) start_cnt++;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [WORD_W-1:0] d, input int gap);
    for (int g = 0; g < gap; g++) step();
    check("wr_ready_in_load", wr_ready, 1);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  task automatic write_block(input logic [511:0] blk, input int gap);
    for (int i = 0; i < 4; i++) write_word(blk[511 - i*128 -: 128], gap);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] w0, w1, w2, w3;
    int           gap;
    int           wait_cyc;
    logic [255:0] hash;
    logic [511:0] exp_msg;
  } vec_t;

  vec_t         vecs[4];
  int           base;
  logic [511:0] e;
  logic [255:0] last_hash;

  initial begin
    vecs[0] = '{w0: 128'h61626380_00000000_00000000_00000000, w1: '0, w2: '0,
                w3: 128'h00000000_00000000_00000000_00000018,
                gap: 0, wait_cyc: 5, hash: ABC_HASH, exp_msg: ABC_MSG};
    vecs[1] = '{w0: 128'h61626380_00000000_00000000_00000000, w1: '0, w2: '0,
                w3: 128'h00000000_00000000_00000000_00000018,
                gap: 3, wait_cyc: 2, hash: ABC_HASH, exp_msg: ABC_MSG};
    vecs[2] = '{w0: 128'h80000000_00000000_00000000_00000000, w1: '0, w2: '0, w3: '0,
                gap: 1, wait_cyc: 0, hash: EMPTY_HASH, exp_msg: EMPTY_MSG};
    vecs[3] = '{w0: 128'h00112233_44556677_8899aabb_ccddeeff,
                w1: 128'h01234567_89abcdef_fedcba98_76543210,
                w2: 128'hffffffff_00000000_ffffffff_00000000,
                w3: 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978,
                gap: 0, wait_cyc: 1, hash: PAT_HASH, exp_msg: PAT_MSG};

    // ---- reset state ----
    step();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_message", message, 0);
    check("rst_hash_out", hash_out, 0);
    check("rst_hash_valid", hash_valid, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    clr = 1'b1;
    #1;
    check("post_rst_wr_ready", wr_ready, 1);

    // ---- core_valid ignored in LOAD and START ----
    core_valid = 1'b1;
    core_hash  = JUNK_HASH;
    step();
    step();
    core_valid = 1'b0;
    check("load_cv_ignored_hv", hash_valid, 0);
    check("load_cv_ignored_ho", hash_out, 0);
    write_block(ABC_MSG, 0);
    check("seqb_start", start, 1);
    core_valid = 1'b1;
    step();
    core_valid = 1'b0;
    check("start_cv_ignored_busy", busy, 1);
    check("start_cv_ignored_hv", hash_valid, 0);
    check("start_cv_ignored_ho", hash_out, 0);
    core_valid = 1'b1;
    core_hash  = ABC_HASH;
    step();
    core_valid = 1'b0;
    core_hash  = JUNK_HASH;
    check("seqb_hash_out", hash_out, ABC_HASH);
    check("seqb_hash_valid", hash_valid, 1);

    // ---- table-driven blocks ----
    for (int n = 0; n < 4; n++) begin
      base = start_cnt;
      check("hv_held_before_block", hash_valid, 1);
      write_word(vecs[n].w0, vecs[n].gap);
      check("hv_clr_first_word", hash_valid, 0);
      write_word(vecs[n].w1, vecs[n].gap);
      write_word(vecs[n].w2, vecs[n].gap);
      check("no_start_before_last", start_cnt - base, 0);
      check("busy_during_load", busy, 0);
      write_word(vecs[n].w3, vecs[n].gap);
      check("start_pulse", start, 1);
      check("busy_in_start", busy, 1);
      check("wr_ready_in_start", wr_ready, 0);
      check("message", message, vecs[n].exp_msg);
      step();
      check("start_one_cycle", start, 0);
      check("busy_in_wait", busy, 1);
      for (int c = 0; c < vecs[n].wait_cyc; c++) step();
      core_valid = 1'b1;
      core_hash  = vecs[n].hash;
      step();
      core_valid = 1'b0;
      core_hash  = JUNK_HASH;
      check("hash_out", hash_out, vecs[n].hash);
      check("hash_valid", hash_valid, 1);
      check("busy_after_hash", busy, 0);
      check("start_count", start_cnt - base, 1);
      check("message_held", message, vecs[n].exp_msg);
    end

    // ---- writes while busy are dropped; next write lands at 511:384 ----
    write_block(ABC_MSG, 0);
    wr_en   = 1'b1;
    wr_data = {4{32'hdeadbeef}};
    for (int c = 0; c < 4; c++) begin
      check("busy_wr_ready", wr_ready, 0);
      step();
    end
    core_valid = 1'b1;
    core_hash  = ABC_HASH;
    step();
    wr_en      = 1'b0;
    core_valid = 1'b0;
    check("busy_msg_unchanged", message, ABC_MSG);
    check("busy_hash_valid", hash_valid, 1);
    write_word(128'ha5a5a5a5_5a5a5a5a_a5a5a5a5_5a5a5a5a, 0);
    e = ABC_MSG;
    e[511:384] = 128'ha5a5a5a5_5a5a5a5a_a5a5a5a5_5a5a5a5a;
    check("first_slot_after_hash", message, e);

    // ---- reset mid-block ----
    write_word(128'h11111111_22222222_33333333_44444444, 0);
    clr = 1'b0;
    step();
    check("midrst_wr_ready", wr_ready, 0);
    check("midrst_message", message, 0);
    check("midrst_hash_valid", hash_valid, 0);
    check("midrst_hash_out", hash_out, 0);
    check("midrst_busy", busy, 0);
    clr = 1'b1;
    #1;
    check("midrst_ready_back", wr_ready, 1);
    write_block(EMPTY_MSG, 0);
    check("midrst_fresh_block", message, EMPTY_MSG);
    check("midrst_start", start, 1);
    step();
    core_valid = 1'b1;
    core_hash  = EMPTY_HASH;
    step();
    core_valid = 1'b0;
    check("midrst_hash_out2", hash_out, EMPTY_HASH);
    last_hash = EMPTY_HASH;

`ifdef SHA_LOADER_TIMEOUT_EN
    // ---- WAIT timeout ----
    write_block(PAT_MSG, 0);
    step();
    for (int c = 0; c < TO_CYC - 1; c++) step();
    check("to_still_waiting", busy, 1);
    step();
    check("to_back_in_load", busy, 0);
    check("to_err_set", timeout_err, 1);
    check("to_hv_clear", hash_valid, 0);
    check("to_hash_unchanged", hash_out, last_hash);
    write_word(vecs[3].w0, 0);
    check("to_err_cleared", timeout_err, 0);
    write_word(vecs[3].w1, 0);
    write_word(vecs[3].w2, 0);
    write_word(vecs[3].w3, 0);
    step();
    core_valid = 1'b1;
    core_hash  = PAT_HASH;
    step();
    core_valid = 1'b0;
    check("to_recover_hash", hash_out, PAT_HASH);
`else
    check("to_tied_zero", timeout_err, 0);
    check("hash_kept", hash_out, last_hash);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
